// File: rtl/key_matrix_scanner.sv
// Matrix keypad scanner: 2-flop synchronised rows, per-frame debounce, press/release/repeat events.
// Latency <= 2 + (DEBOUNCE+1)*COLS*TICK_DIV clk; busy output stalls press/release, drops repeats.
module key_matrix_scanner #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int TICK_DIV    = 50000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100,
    localparam int CODE_W     = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_repeat,
    output logic              key_held,
    output logic              multi_key,
    output logic              ev_drop
);
    localparam int  TICK_W = $clog2(TICK_DIV);
    localparam int  CIDX_W = $clog2(COLS);
    localparam int  REP_W  = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    localparam bit  REP_EN = (REPEAT_DLY > 0);
    localparam logic [1:0] CLS_NONE = 2'd0, CLS_SINGLE = 2'd1, CLS_MULTI = 2'd2;
    localparam logic [0:0] ST_IDLE = 1'b0, ST_HELD = 1'b1;

    logic [ROWS-1:0]   r_row_s1, r_row_s2;
    logic              r_scan_en;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [CIDX_W-1:0] r_col_idx;
    logic [1:0]        r_acc_hits;
    logic [CODE_W-1:0] r_acc_code;
    logic [1:0]        r_prev_cls, r_stable_cls;
    logic [CODE_W-1:0] r_prev_code, r_stable_code;
    logic [3:0]        r_db_cnt;
    logic [0:0]        r_state;
    logic [CODE_W-1:0] r_held_code;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_rep_first;
    logic              r_key_valid, r_key_release, r_key_repeat, r_multi, r_ev_drop;
    logic [CODE_W-1:0] r_key_code;
    logic              r_q_vld;
    logic [CODE_W-1:0] r_q_code;

    logic              w_tick_end, w_frame_end;
    logic [1:0]        w_hits, w_frm_cls;
    logic [CODE_W-1:0] w_code, w_frm_code;
    logic              w_db_match;
    logic [3:0]        w_db_nxt;
    logic              w_want_press, w_want_rel, w_want_swap, w_want, w_slot_free;
    logic              w_fsm_go, w_fsm_stall;
    logic              w_rep_tick, w_rep_fire, w_rep_issue, w_rep_drop;
    logic [REP_W-1:0]  w_rep_nxt;

    assign w_tick_end  = r_scan_en && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_frame_end = w_tick_end && (r_col_idx == CIDX_W'(COLS - 1));
    assign col         = r_scan_en ? ~(COLS'(1) << r_col_idx) : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1   <= '1;
            r_row_s2   <= '1;
            r_scan_en  <= 1'b0;
            r_tick_cnt <= '0;
            r_col_idx  <= '0;
        end else begin
            r_row_s1  <= row;
            r_row_s2  <= r_row_s1;
            r_scan_en <= 1'b1;
            if (w_tick_end) begin
                r_tick_cnt <= '0;
                r_col_idx  <= (r_col_idx == CIDX_W'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
            end else if (r_scan_en) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Hit count saturates at 2: only NONE / SINGLE / MULTI matter.
    always_comb begin
        w_hits = r_acc_hits;
        w_code = r_acc_code;
        for (int r = 0; r < ROWS; r++) begin
            if (!r_row_s2[r]) begin
                if (w_hits == 2'd0) w_code = CODE_W'(r * COLS) + CODE_W'(r_col_idx);
                if (w_hits != 2'd2) w_hits = w_hits + 2'd1;
            end
        end
        w_frm_cls  = (w_hits == 2'd0) ? CLS_NONE : (w_hits == 2'd1) ? CLS_SINGLE : CLS_MULTI;
        w_frm_code = (w_hits == 2'd1) ? w_code : '0;
        w_db_match = (w_frm_cls == r_prev_cls) && (w_frm_code == r_prev_code);
        w_db_nxt   = !w_db_match ? 4'd1 : (r_db_cnt == 4'(DEBOUNCE)) ? r_db_cnt : r_db_cnt + 4'd1;
    end

    always_comb begin
        w_want_press = (r_state == ST_IDLE) && (r_stable_cls == CLS_SINGLE);
        w_want_rel   = (r_state == ST_HELD) && (r_stable_cls == CLS_NONE);
        w_want_swap  = (r_state == ST_HELD) && (r_stable_cls == CLS_SINGLE) &&
                       (r_stable_code != r_held_code);
        w_want       = w_want_press || w_want_rel || w_want_swap;
        w_slot_free  = (!r_key_valid || key_ready) && !r_q_vld;
        w_fsm_go     = w_want && w_slot_free;
        w_fsm_stall  = w_want && !w_slot_free;
        w_rep_tick   = REP_EN && (r_state == ST_HELD) && (r_stable_cls != CLS_MULTI) && w_tick_end;
        w_rep_nxt    = r_rep_cnt + 1'b1;
        w_rep_fire   = w_rep_tick &&
                       (w_rep_nxt == (r_rep_first ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE)));
        w_rep_issue  = w_rep_fire && !w_fsm_go && w_slot_free;
        w_rep_drop   = w_rep_fire && !w_rep_issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hits    <= '0;
            r_acc_code    <= '0;
            r_prev_cls    <= CLS_NONE;
            r_prev_code   <= '0;
            r_stable_cls  <= CLS_NONE;
            r_stable_code <= '0;
            r_db_cnt      <= '0;
        end else begin
            if (w_tick_end) begin
                r_acc_hits <= w_frame_end ? 2'd0 : w_hits;
                r_acc_code <= w_frame_end ? '0 : w_code;
            end
            // Frames arriving while an event is blocked are ignored so the stable state holds.
            if (w_frame_end && !w_fsm_stall) begin
                r_prev_cls  <= w_frm_cls;
                r_prev_code <= w_frm_code;
                r_db_cnt    <= w_db_nxt;
                if (w_db_nxt == 4'(DEBOUNCE)) begin
                    r_stable_cls  <= w_frm_cls;
                    r_stable_code <= w_frm_code;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_held_code   <= '0;
            r_rep_cnt     <= '0;
            r_rep_first   <= 1'b1;
            r_key_valid   <= 1'b0;
            r_key_code    <= '0;
            r_key_release <= 1'b0;
            r_key_repeat  <= 1'b0;
            r_q_vld       <= 1'b0;
            r_q_code      <= '0;
            r_multi       <= 1'b0;
            r_ev_drop     <= 1'b0;
        end else begin
            r_ev_drop <= w_rep_drop;
            r_multi   <= (r_stable_cls == CLS_MULTI);
            if (r_key_valid && key_ready) r_key_valid <= 1'b0;
            if (r_q_vld && (!r_key_valid || key_ready)) begin
                r_key_valid   <= 1'b1;
                r_key_code    <= r_q_code;
                r_key_release <= 1'b0;
                r_key_repeat  <= 1'b0;
                r_q_vld       <= 1'b0;
            end
            if (w_rep_tick && !w_fsm_go) begin
                r_rep_cnt <= w_rep_fire ? '0 : w_rep_nxt;
                if (w_rep_fire) r_rep_first <= 1'b0;
            end
            if (w_fsm_go) begin
                r_key_valid  <= 1'b1;
                r_key_repeat <= 1'b0;
                r_rep_cnt    <= '0;
                r_rep_first  <= 1'b1;
                if (w_want_press) begin
                    r_key_code    <= r_stable_code;
                    r_key_release <= 1'b0;
                    r_state       <= ST_HELD;
                    r_held_code   <= r_stable_code;
                end else begin
                    // Release the old key now; a key change parks the new press in the queue.
                    r_key_code    <= r_held_code;
                    r_key_release <= 1'b1;
                    if (w_want_swap) begin
                        r_q_vld     <= 1'b1;
                        r_q_code    <= r_stable_code;
                        r_held_code <= r_stable_code;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            end else if (w_rep_issue) begin
                r_key_valid   <= 1'b1;
                r_key_code    <= r_held_code;
                r_key_release <= 1'b0;
                r_key_repeat  <= 1'b1;
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_release = r_key_release;
    assign key_repeat  = r_key_repeat;
    assign key_held    = (r_state == ST_HELD);
    assign multi_key   = r_multi;
    assign ev_drop     = r_ev_drop;
endmodule
